s420_stim_driver: RTL and testbench

Stimulus and capture engine for the s420 counter/compare core. It loads the 17-bit compare mask onto the core's C_0..C_16 inputs and steps the core's count enable P_0 for a programmed number of cycles. While stepping, it samples the core's match output Z and reports the hit count and the step index of the first hit. It sits between a host configuration port and the s420 instance, on the core's clock.

---
 rtl/s420_stim_driver.sv | 149 ++++++++++++++
 tb/tb_s420_stim_driver.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s420_stim_driver.sv
// s420_stim_driver
// Stimulus and capture engine for the s420 counter/compare core.
// A host job loads a 17-bit compare mask onto C and sets a step count. The
// block then holds P_0 high for that many cycles. It samples the core's match
// output Z on each of those cycles and keeps three results: the hit count, the
// step index of the first hit, and a hit-seen flag.
// Job flow: IDLE -> SETTLE (one cycle, C settles) -> RUN (P_0 high) -> DONE
// (one-cycle done pulse) -> IDLE. A zero-step job goes from IDLE straight to DONE.

module s420_stim_driver #(
    parameter int MASK_W = 17,
    parameter int STEP_W = 8
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [MASK_W-1:0] cfg_mask,
    input  logic [STEP_W-1:0] cfg_steps,
    input  logic              abort,
    output logic              P_0,
    output logic [MASK_W-1:0] C,
    input  logic              Z,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] hit_count,
    output logic [STEP_W-1:0] first_hit,
    output logic              hit_seen
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_RUN    = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_cfg_ready;
    logic              r_p0;
    logic              r_busy;
    logic              r_done;
    logic              r_hit_seen;
    logic [MASK_W-1:0] r_c;
    logic [STEP_W-1:0] r_remaining;
    logic [STEP_W-1:0] r_step_idx;
    logic [STEP_W-1:0] r_hit_count;
    logic [STEP_W-1:0] r_first_hit;

    logic              w_accept;
    logic              w_last_step;

    // A job is taken only while ready is advertised. Any cfg_valid that arrives
    // while the block is busy or in DONE is dropped.
    assign w_accept    = cfg_valid & r_cfg_ready;
    // RUN ends on the sample that uses up the remaining count, or on an abort.
    // If both happen on the same edge, the exit is still a single transition.
    assign w_last_step = (r_remaining == STEP_W'(1)) || abort;

    // Job sequencer: state, registered core drive, and result capture
    // NOTE: every register here updates with non-blocking assignments, so each
    // branch reads the pre-edge values (e.g. r_step_idx is the index of the
    // sample being taken now, not the incremented one).
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_cfg_ready <= 1'b0;
            r_p0        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_hit_seen  <= 1'b0;
            r_c         <= '0;
            r_remaining <= '0;
            r_step_idx  <= '0;
            r_hit_count <= '0;
            r_first_hit <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cfg_ready <= 1'b1;
                    if (w_accept) begin
                        r_c         <= cfg_mask;
                        r_remaining <= cfg_steps;
                        r_step_idx  <= '0;
                        r_hit_count <= '0;
                        r_first_hit <= '0;
                        r_hit_seen  <= 1'b0;
                        r_cfg_ready <= 1'b0;
                        if (cfg_steps == '0) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_busy  <= 1'b1;
                            r_state <= S_SETTLE;
                        end
                    end
                end

                S_SETTLE: begin
                    // C has been stable at the core for one full cycle, so
                    // stepping can start.
                    r_p0    <= 1'b1;
                    r_state <= S_RUN;
                end

                S_RUN: begin
                    // NOTE: Z is combinational in the core and depends on P_0
                    // in the same cycle. It is therefore sampled at the edge
                    // that closes each P_0-high cycle, not one cycle later.
                    if (Z) begin
                        r_hit_count <= r_hit_count + STEP_W'(1);
                        if (!r_hit_seen) begin
                            r_first_hit <= r_step_idx;
                            r_hit_seen  <= 1'b1;
                        end
                    end
                    r_step_idx  <= r_step_idx + STEP_W'(1);
                    r_remaining <= r_remaining - STEP_W'(1);
                    if (w_last_step) begin
                        r_p0    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end

                S_DONE: begin
                    r_done      <= 1'b0;
                    r_cfg_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cfg_ready = r_cfg_ready;
    assign P_0       = r_p0;
    assign C         = r_c;
    assign busy      = r_busy;
    assign done      = r_done;
    assign hit_count = r_hit_count;
    assign first_hit = r_first_hit;
    assign hit_seen  = r_hit_seen;

endmodule

// File: tb/tb_s420_stim_driver.sv
// tb_s420_stim_driver
// Bench for s420_stim_driver. It plays the s420 core: Z and abort are driven
// from a per-job table indexed by the number of P_0-high cycles seen so far.
// When a job is issued, its expected outcome is computed from the job
// description and queued. A monitor takes each done pulse, pops the next
// expected outcome and compares it with the DUT outputs.

module tb_s420_stim_driver;

    logic        CK = 1'b0;
    logic        RST;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [16:0] cfg_mask;
    logic [7:0]  cfg_steps;
    logic        abort = 1'b0;
    logic        P_0;
    logic [16:0] C;
    logic        Z = 1'b0;
    logic        busy;
    logic        done;
    logic [7:0]  hit_count;
    logic [7:0]  first_hit;
    logic        hit_seen;

    s420_stim_driver #(.MASK_W(17), .STEP_W(8)) dut (
        .CK        (CK),
        .RST       (RST),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_mask  (cfg_mask),
        .cfg_steps (cfg_steps),
        .abort     (abort),
        .P_0       (P_0),
        .C         (C),
        .Z         (Z),
        .busy      (busy),
        .done      (done),
        .hit_count (hit_count),
        .first_hit (first_hit),
        .hit_seen  (hit_seen)
    );

    initial forever #5 CK = ~CK;

    // Counts rising edges, so job latencies can be checked in cycles.
    int cyc = 0;
    always @(posedge CK) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected outcome of one job
    typedef struct {
        int mask;
        int len;    // number of P_0-high cycles
        int hits;
        int first;
        int seen;
        int c0;     // cycle count just after the accepting edge
    } exp_t;

    exp_t exp_q[$];

    // The current job's Z table and abort step, read by the core model below
    logic [255:0] cur_zpat  = '0;
    int           cur_abort = -1;

    // Reference model: steps actually run, then hit statistics over them
    function automatic exp_t model(input int mask, input int steps,
                                   input logic [255:0] zp, input int ab, input int c0);
        exp_t e;
        e.mask  = mask;
        e.len   = (ab >= 0 && ab < steps) ? ab + 1 : steps;
        e.hits  = 0;
        e.first = 0;
        e.seen  = 0;
        e.c0    = c0;
        for (int i = 0; i < e.len; i++) begin
            if (zp[i]) begin
                if (e.seen == 0) begin
                    e.first = i;
                    e.seen  = 1;
                end
                e.hits++;
            end
        end
        return e;
    endfunction

    // Core model: while P_0 is high, present Z and abort for step k. Otherwise
    // drive random junk, which the DUT must ignore.
    int zk = 0;
    always @(negedge CK) begin
        if (P_0 === 1'b1) begin
            Z     = cur_zpat[zk];
            abort = (zk == cur_abort);
            zk++;
        end else begin
            zk    = 0;
            Z     = 1'($urandom_range(0, 1));
            abort = 1'($urandom_range(0, 1));
        end
    end

    // Monitor / scoreboard
    int   p0_cnt = 0;
    logic prev_p0 = 1'b0;
    logic hold_pending = 1'b0;
    exp_t hold_e;
    always @(negedge CK) begin
        if (RST !== 1'b0) begin
            p0_cnt       = 0;
            prev_p0      = 1'b0;
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check("hold_hit_count", int'(hit_count), hold_e.hits);
                check("hold_first_hit", int'(first_hit), hold_e.first);
                check("hold_hit_seen",  int'(hit_seen),  hold_e.seen);
                check("hold_C",         int'(C),         hold_e.mask);
                check("done_one_cycle", int'(done),      0);
                check("ready_after_done", int'(cfg_ready), 1);
                hold_pending = 1'b0;
            end
            if (P_0 === 1'b1) begin
                check("busy_with_p0", int'(busy), 1);
                if (!prev_p0 && exp_q.size() > 0)
                    check("p0_start_cycle", cyc, exp_q[0].c0 + 1);
                p0_cnt++;
            end
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("hit_count", int'(hit_count), e.hits);
                    check("first_hit", int'(first_hit), e.first);
                    check("hit_seen",  int'(hit_seen),  e.seen);
                    check("C",         int'(C),         e.mask);
                    check("p0_cycles", p0_cnt,          e.len);
                    check("done_cycle", cyc, e.c0 + ((e.len == 0) ? 0 : e.len + 1));
                    check("done_busy",  int'(busy),      0);
                    check("done_ready", int'(cfg_ready), 0);
                    check("done_p0",    int'(P_0),       0);
                    hold_e       = e;
                    hold_pending = 1'b1;
                end
                p0_cnt = 0;
            end
            prev_p0 = P_0;
        end
    end

    // Issue one job: wait for ready, queue its expected outcome, pulse cfg_valid.
    // Called and returns on a falling edge.
    task automatic issue(input logic [16:0] mask, input int steps,
                         input logic [255:0] zp, input int ab);
        int waited = 0;
        while (cfg_ready !== 1'b1 && waited < 2000) begin
            @(negedge CK);
            waited++;
        end
        if (cfg_ready !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL cfg_ready_timeout: got %0d, expected 1", cfg_ready);
        end
        cur_zpat  = zp;
        cur_abort = ab;
        exp_q.push_back(model(int'(mask), steps, zp, ab, cyc + 1));
        cfg_mask  = mask;
        cfg_steps = 8'(steps);
        cfg_valid = 1'b1;
        @(negedge CK);
        cfg_valid = 1'b0;
        cfg_mask  = 17'($urandom());
        cfg_steps = 8'($urandom());
    endtask

    function automatic logic [255:0] rand_zpat();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    initial begin
        logic [255:0] zp;
        int           steps;
        int           ab;
        int           w;

        // Reset held with cfg_valid high: everything low, nothing accepted
        RST       = 1'b1;
        cfg_valid = 1'b1;
        cfg_mask  = 17'h1abcd;
        cfg_steps = 8'd5;
        repeat (3) begin
            @(negedge CK);
            check("rst_ready",     int'(cfg_ready), 0);
            check("rst_p0",        int'(P_0),       0);
            check("rst_C",         int'(C),         0);
            check("rst_busy",      int'(busy),      0);
            check("rst_done",      int'(done),      0);
            check("rst_hit_count", int'(hit_count), 0);
            check("rst_first_hit", int'(first_hit), 0);
            check("rst_hit_seen",  int'(hit_seen),  0);
        end
        RST       = 1'b0;
        cfg_valid = 1'b0;
        #1;
        check("ready_before_clock", int'(cfg_ready), 0);
        @(negedge CK);
        check("ready_after_release", int'(cfg_ready), 1);
        check("no_job_in_reset_C",   int'(C),         0);
        check("no_job_in_reset_busy", int'(busy),     0);

        // Constant hit
        issue(17'h00001, 5, {256{1'b1}}, -1);
        // Zero steps
        issue(17'h0f0f0, 0, {256{1'b1}}, -1);
        // Sparse hits at steps 3 and 7
        zp = '0; zp[3] = 1'b1; zp[7] = 1'b1;
        issue(17'h12345, 10, zp, -1);
        // Abort on step 4, with a hit on step 4
        zp = '0; zp[4] = 1'b1;
        issue(17'h00f00, 10, zp, 4);
        // Abort on the last step
        zp = '0; zp[9] = 1'b1; zp[2] = 1'b1;
        issue(17'h1ffff, 10, zp, 9);
        // Longest job, single hit on the last possible index
        zp = '0; zp[254] = 1'b1;
        issue(17'h0aaaa, 255, zp, -1);

        // Reset in the middle of RUN
        issue(17'h15555, 20, {256{1'b1}}, -1);
        w = 0;
        while (P_0 !== 1'b1 && w < 10) begin
            @(negedge CK);
            w++;
        end
        repeat (4) @(negedge CK);
        check("midrun_hits_before_rst", int'(hit_seen), 1);
        #2 RST = 1'b1;
        #1;
        check("midrun_p0",        int'(P_0),       0);
        check("midrun_busy",      int'(busy),      0);
        check("midrun_C",         int'(C),         0);
        check("midrun_hit_count", int'(hit_count), 0);
        check("midrun_hit_seen",  int'(hit_seen),  0);
        check("midrun_done",      int'(done),      0);
        exp_q.delete();
        repeat (2) @(negedge CK);
        RST = 1'b0;
        @(negedge CK);

        // A normal job after reset, with cfg_valid pulses while busy
        zp = rand_zpat();
        issue(17'h10000, 3, zp, -1);
        cfg_valid = 1'b1;
        cfg_mask  = 17'h1ffff;
        cfg_steps = 8'd7;
        repeat (2) @(negedge CK);
        cfg_valid = 1'b0;

        // Random jobs
        for (int j = 0; j < 24; j++) begin
            case ($urandom_range(0, 9))
                0:       steps = 0;
                1:       steps = 255;
                default: steps = $urandom_range(1, 40);
            endcase
            ab = ($urandom_range(0, 2) == 0 && steps > 0) ? $urandom_range(0, steps + 4) : -1;
            zp = ($urandom_range(0, 4) == 0) ? '0 : rand_zpat();
            issue(17'($urandom()), steps, zp, ab);
        end

        // Drain the scoreboard
        w = 0;
        while (exp_q.size() != 0 && w < 1000) begin
            @(negedge CK);
            w++;
        end
        check("scoreboard_drained", exp_q.size(), 0);
        repeat (3) @(negedge CK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Guard against a hang
    initial begin
        #500000;
        $display("FAIL global_timeout: got time %0t, expected completion earlier", $time);
        $fatal(1, "timeout");
    end

endmodule
